// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_lite_pkg : response codes, FSM encodings and range helper
// Rev 1.0
// ------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_EXEC    = 2'd1,
    W_RESP    = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_MEM  = 2'd2,
    R_RESP = 2'd3
  } rstate_e;

  // An address is backed by RAM only if nothing is set above the byte span.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned abits);
    return (addr >> abits) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sp_be.sv
`default_nettype none
// ------------------------------------------------------------------
// bram_sp_be : single-port 32-bit RAM, byte enables, 1-cycle write-first read
// Rev 1.0
// ------------------------------------------------------------------
module bram_sp_be #(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int          c_DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] c_INIT_WORD = (INIT_ZERO != 0) ? 32'h0 : 32'hx;

  logic [31:0] mem_q [c_DEPTH] = '{default: c_INIT_WORD};
  logic [31:0] rdata_q;
  logic [31:0] w_merged;

  // Write-first: enabled bytes return the incoming data on the same access.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign w_merged[8*b +: 8] = we_i[b] ? wdata_i[8*b +: 8] : mem_q[addr_i][8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= w_merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_dmem.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_lite_dmem : AXI4-Lite data-memory slave over one single-port RAM
// Rev 1.0
// ------------------------------------------------------------------
module axi_lite_dmem
  import axi_lite_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int c_WORD_BITS = ADDR_BITS - 2;

  wstate_e     wstate_q, wstate_d;
  logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  rstate_e     rstate_q, rstate_d;
  logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic                   w_aw_hs, w_w_hs, w_ar_hs;
  logic                   w_aw_in_range, w_ar_in_range;
  logic                   w_wr_exec, w_rd_issue, w_ram_en;
  logic [3:0]             w_ram_we;
  logic [c_WORD_BITS-1:0] w_ram_addr;
  logic [31:0]            w_ram_rdata;
  logic                   unused_ok;

  // Readies/valids come from registered state only; rst forces them low.
  assign axi_awready = !rst && (wstate_q == W_COLLECT) && !aw_lat_q;
  assign axi_wready  = !rst && (wstate_q == W_COLLECT) && !w_lat_q;
  assign axi_bvalid  = !rst && (wstate_q == W_RESP);
  assign axi_bresp   = bresp_q;
  assign axi_arready = !rst && (rstate_q == R_IDLE);
  assign axi_rvalid  = !rst && (rstate_q == R_RESP);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;

  assign w_aw_hs       = axi_awvalid && axi_awready;
  assign w_w_hs        = axi_wvalid && axi_wready;
  assign w_ar_hs       = axi_arvalid && axi_arready;
  assign w_aw_in_range = addr_in_range(awaddr_q, ADDR_BITS);
  assign w_ar_in_range = addr_in_range(araddr_q, ADDR_BITS);

  // The write owns the port during W_EXEC; a pending read waits one cycle.
  assign w_wr_exec  = (wstate_q == W_EXEC);
  assign w_rd_issue = (rstate_q == R_WAIT) && !w_wr_exec;
  assign w_ram_we   = (w_wr_exec && w_aw_in_range && !rst) ? wstrb_q : 4'b0000;
  assign w_ram_en   = (w_wr_exec && !rst) || w_rd_issue;
  assign w_ram_addr = w_wr_exec ? awaddr_q[ADDR_BITS-1:2] : araddr_q[ADDR_BITS-1:2];

  assign unused_ok = ^{axi_arprot, axi_awprot, araddr_q[1:0], awaddr_q[1:0]};

  always_comb begin
    wstate_d = wstate_q;
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_COLLECT: begin
        if (w_aw_hs) begin
          aw_lat_d = 1'b1;
          awaddr_d = axi_awaddr;
        end
        if (w_w_hs) begin
          w_lat_d = 1'b1;
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
        end
        if (aw_lat_d && w_lat_d) wstate_d = W_EXEC;
      end
      W_EXEC: begin
        bresp_d  = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        if (axi_bready) begin
          wstate_d = W_COLLECT;
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
        end
      end
      default: wstate_d = W_COLLECT;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          araddr_d = axi_araddr;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: if (w_rd_issue) rstate_d = R_MEM;
      R_MEM: begin
        rdata_d  = w_ar_in_range ? w_ram_rdata : 32'h0;
        rresp_d  = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        rstate_d = R_RESP;
      end
      R_RESP: if (axi_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_COLLECT;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      awaddr_q <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      bresp_q  <= 2'b00;
      rstate_q <= R_IDLE;
      araddr_q <= 32'h0;
      rdata_q  <= 32'h0;
      rresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      aw_lat_q <= aw_lat_d;
      w_lat_q  <= w_lat_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  bram_sp_be #(
    .ADDR_W    (c_WORD_BITS),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .clk     (clk),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (w_ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_dmem.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_axi_lite_dmem : directed and randomized checks against a word-array model
// Rev 1.0
// ------------------------------------------------------------------
module tb_axi_lite_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = '0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ram_writes = 0;
  logic [31:0] model [1024];

  axi_lite_dmem #(.ADDR_BITS(12), .INIT_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dut.w_ram_we != 4'b0000) ram_writes <= ram_writes + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic in_range(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_range(a) ? model[a[11:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic drive_aw(input logic [31:0] a, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    axi_awaddr = a; axi_awvalid = 1'b1;
    while (axi_awready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL aw_timeout: waited %0d cycles, required < 100", t); end
    @(negedge clk); axi_awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
    while (axi_wready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL w_timeout: waited %0d cycles, required < 100", t); end
    @(negedge clk); axi_wvalid = 1'b0;
  endtask

  task automatic collect_b(output logic [1:0] resp);
    int t = 0;
    while (axi_bvalid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL b_timeout: waited %0d cycles, required < 100", t); end
    resp = axi_bresp; axi_bready = 1'b1;
    @(negedge clk); axi_bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, output logic [1:0] resp);
    fork
      drive_aw(a, awd);
      drive_w(d, s, wd);
    join
    collect_b(resp);
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t = 0;
    int hs;
    axi_araddr = a; axi_arvalid = 1'b1;
    while (axi_arready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL ar_timeout: waited %0d cycles, required < 100", t); end
    hs = cyc;
    @(negedge clk); axi_arvalid = 1'b0;
    t = 0;
    while (axi_rvalid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; errors++; $display("FAIL r_timeout: waited %0d cycles, required < 100", t); end
    lat = cyc - hs; data = axi_rdata; resp = axi_rresp; axi_rready = 1'b1;
    @(negedge clk); axi_rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid});
    end
    checks++;
    if (axi_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", axi_rdata); end
    checks++;
    if ({axi_rresp, axi_bresp} !== 4'b0) begin errors++; $display("FAIL reset_resp: got %b required 0000", {axi_rresp, axi_bresp}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b required 111", {axi_arready, axi_awready, axi_wready});
    end
  endtask

  task automatic test_full_write_read;
    logic [1:0] resp; logic [31:0] data; int lat;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 3, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL wr_0x10_bresp: got %b required 00", resp); end
    do_read(32'h10, data, resp, lat);
    checks++;
    if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_0x10_data: got %h required deadbeef", data); end
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL rd_0x10_rresp: got %b required 00", resp); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_0x10_latency: got %0d required 3", lat); end
  endtask

  task automatic test_byte_strobe;
    logic [1:0] resp; logic [31:0] data, d; logic [3:0] s; int lat;
    do_write(32'h10, 32'h000000AA, 4'h1, 0, 0, resp);
    do_read(32'h10, data, resp, lat);
    checks++;
    if (data !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_lsb: got %h required deadbeaa", data); end
    for (int i = 0; i < 4; i++) begin
      s = 4'($urandom_range(1, 15)); d = $urandom();
      do_write(32'h18, d, s, 0, 0, resp);
      do_read(32'h18, data, resp, lat);
      checks++;
      if (data !== exp_rdata(32'h18)) begin
        errors++; $display("FAIL strobe_rand strb=%h: got %h required %h", s, data, exp_rdata(32'h18));
      end
    end
  endtask

  task automatic test_w_first_backpressure;
    logic [1:0] resp, r0; logic [31:0] data; int lat, base, t;
    base = ram_writes;
    fork
      drive_aw(32'h14, 2);
      drive_w(32'hCAFEF00D, 4'hF, 0);
    join
    t = 0;
    while (axi_bvalid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    r0 = axi_bresp;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (axi_bvalid !== 1'b1 || axi_bresp !== r0) begin
        errors++; $display("FAIL b_hold cycle %0d: bvalid=%b bresp=%b required 1/%b", i, axi_bvalid, axi_bresp, r0);
      end
      @(negedge clk);
    end
    collect_b(resp);
    model_write(32'h14, 32'hCAFEF00D, 4'hF);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL b_hold_resp: got %b required 00", resp); end
    checks++;
    if (ram_writes - base !== 1) begin errors++; $display("FAIL b_hold_writes: got %0d required 1", ram_writes - base); end
    do_write(32'h1C, 32'h5A5A1234, 4'hF, 0, 0, resp);
    do_read(32'h14, data, resp, lat);
    checks++;
    if (data !== 32'hCAFEF00D) begin errors++; $display("FAIL w_first_data: got %h required cafef00d", data); end
    do_read(32'h1C, data, resp, lat);
    checks++;
    if (data !== 32'h5A5A1234) begin errors++; $display("FAIL same_cycle_data: got %h required 5a5a1234", data); end
  endtask

  task automatic test_conflict;
    logic [1:0] wresp, rresp; logic [31:0] data; int lat;
    do_write(32'h20, 32'h1, 4'hF, 0, 0, wresp);
    fork
      do_write(32'h20, 32'h2, 4'hF, 0, 0, wresp);
      do_read(32'h20, data, rresp, lat);
    join
    checks++;
    if (data !== 32'h2) begin errors++; $display("FAIL conflict_data: got %h required 2", data); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL conflict_latency: got %0d required 4", lat); end
    checks++;
    if (wresp !== 2'b00 || rresp !== 2'b00) begin errors++; $display("FAIL conflict_resp: got %b/%b required 00/00", wresp, rresp); end
  endtask

  task automatic test_out_of_range;
    logic [1:0] resp; logic [31:0] data; int lat;
    do_write(32'h0, 32'h12345678, 4'hF, 0, 0, resp);
    do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b required 10", resp); end
    do_read(32'h1000, data, resp, lat);
    checks++;
    if (resp !== 2'b10 || data !== 32'h0) begin errors++; $display("FAIL oor_read: got %b/%h required 10/00000000", resp, data); end
    do_read(32'h0, data, resp, lat);
    checks++;
    if (data !== 32'h12345678) begin errors++; $display("FAIL oor_word0: got %h required 12345678", data); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp; logic [31:0] data; int lat, t;
    do_write(32'h30, 32'h11111111, 4'hF, 0, 0, resp);
    fork
      drive_aw(32'h30, 0);
      drive_w(32'h22222222, 4'hF, 0);
    join
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({axi_bvalid, axi_rvalid, axi_arready, axi_awready, axi_wready} !== 5'b0) begin
      errors++; $display("FAIL rst_wexec_flags: got %b required 00000", {axi_bvalid, axi_rvalid, axi_arready, axi_awready, axi_wready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
      errors++; $display("FAIL rst_wexec_ready: got %b required 111", {axi_arready, axi_awready, axi_wready});
    end
    do_read(32'h30, data, resp, lat);
    checks++;
    if (data !== 32'h11111111) begin errors++; $display("FAIL rst_wexec_word: got %h required 11111111", data); end
    axi_araddr = 32'h30; axi_arvalid = 1'b1;
    @(negedge clk); axi_arvalid = 1'b0;
    t = 0;
    while (axi_rvalid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_rvalid !== 1'b0 || axi_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rresp: rvalid=%b rdata=%h required 0/00000000", axi_rvalid, axi_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
      errors++; $display("FAIL rst_rresp_ready: got %b required 111", {axi_arready, axi_awready, axi_wready});
    end
  endtask

  task automatic test_random;
    logic [1:0] resp; logic [31:0] a, d, data; logic [3:0] s; int lat;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h0000_1000;
      else a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom(); s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
        checks++;
        if (resp !== exp_resp(a)) begin errors++; $display("FAIL rand_bresp a=%h: got %b required %b", a, resp, exp_resp(a)); end
      end else begin
        do_read(a, data, resp, lat);
        checks++;
        if (data !== exp_rdata(a) || resp !== exp_resp(a)) begin
          errors++; $display("FAIL rand_read a=%h: got %h/%b required %h/%b", a, data, resp, exp_rdata(a), exp_resp(a));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    test_reset();
    test_full_write_read();
    test_byte_strobe();
    test_w_first_backpressure();
    test_conflict();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
